banked_mem_responder: RTL
=========================

Name: banked_mem_responder

Overview:
- Main-memory side of the cache-to-memory interface: the responder that services the cache controller's mem_rd/mem_wr requests.
- Four-way word-interleaved memory. Each bank is occupied for a fixed number of cycles per access, and per-bank occupancy is reported on busy[3:0], which the controller polls.
- Read data returns with fixed latency. Used directly under the cache controller and standalone in memory-system benches.

Parameters:
- ADDR_W, 16, byte-address width; words are 16 bits, so addr[0] must be 0.
- DATA_W, 16, data width.
- BANK_CYCLES, 4, cycles a bank reports busy after accepting an access; legal range 2..15.
- RD_LAT, 2, cycles from accept edge to data_valid; fixed, not tunable beyond 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- addr  in  ADDR_W  byte address; bank = addr[2:1], row = addr[ADDR_W-1:3]
- data_in  in  DATA_W  write data
- rd  in  1  read request
- wr  in  1  write request
- data_out  out  DATA_W  read data, meaningful only when data_valid=1, else 0
- data_valid  out  1  one-cycle pulse marking returned read data
- busy  out  4  per-bank occupancy, registered
- stall  out  1  combinational: request present but target bank busy
- err  out  1  combinational: illegal request this cycle

Behaviour:
- Reset (rst=0, asynchronous): busy=0, all bank counters=0, data_out=0, data_valid=0, read pipeline cleared.
  - Memory array is not reset; contents survive reset.
  - A read in flight at reset is dropped and never returns.
- Request decode, per cycle:
  - req = rd|wr.
  - err = rd&wr | (req & addr[0]).
  - stall = req & ~err & busy[addr[2:1]].
  - accept = req & ~err & ~stall.
  - An err or stall cycle has no side effects. The requester must hold its request until stall drops.
- Accept at rising edge E0 (request presented in cycle C0):
  - Bank counter[b] loads BANK_CYCLES; busy[b] = (counter[b] != 0).
  - Counter decrements each edge. busy[b]=1 in cycles C1..C(BANK_CYCLES) and returns to 0 in cycle C(BANK_CYCLES+1).
  - A request held since C1 to the same bank is accepted at the edge ending cycle C(BANK_CYCLES+1).
- Write: array[b][row] <= data_in at E0. A read accepted later sees the new data.
- Read:
  - Array sampled at E0, then passed through one pipeline register.
  - data_out and data_valid=1 are presented in cycle C2, for exactly one cycle.
  - data_out returns to 0 the following cycle unless another read returns.
- Independent banks:
  - A different bank may be accepted every cycle, so four reads to four banks in C0..C3 return in C2..C5 in order.
  - The read pipeline is one entry per stage, so at most one accept per cycle is possible by construction.
- busy[b] shows only the bank's own counter. The request in the current cycle does not affect busy until the next edge.
- Out-of-range rows cannot occur, since row width = ADDR_W-3 and each bank holds 2^(ADDR_W-3) words.
- Counters saturate at 0; a counter never decrements below zero.

Test Plan:
- Write/read-back:
  - wr addr=0x0010 data=0xBEEF in C0 gives busy=4'b0001 in C1..C4 (bank 0).
  - rd 0x0010 in C5 gives data_out=0xBEEF with data_valid=1 in C7.
- Same-bank conflict:
  - rd 0x0002 in C0, then rd 0x000A held from C1 gives stall=1 in C1..C4.
  - Second read accepted in C5; data_valid pulses in C2 and C7.
- Interleave:
  - rd 0x0000, 0x0002, 0x0004, 0x0006 in C0..C3 gives stall=0 throughout, busy=4'b1111 in C4, and four data_valid pulses in C2..C5 in request order.
- Illegal requests:
  - rd=wr=1 at 0x0004 gives err=1, stall=0, busy unchanged, no data_valid.
  - wr to 0x0003 gives err=1 and memory unchanged; verify by later read.
- Reset mid-operation:
  - rd accepted in C0, rst=0 in C1 gives busy=0 and data_valid=0 immediately, and no return after release.
  - Earlier-written data is still readable.
- BANK_CYCLES=2 build:
  - Back-to-back same-bank writes are accepted every 3rd cycle, with stall=1 in the two cycles between.

Source files
------------

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved memory responder for the cache controller's rd/wr requests.
// Latency: read data returns two cycles after the accepting edge (data_valid_o pulse).
// Backpressure: stall_o is raised while the addressed bank is busy; err/stall cycles have no side effects.
module banked_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BANK_CYCLES = 4,
    parameter int RD_LAT      = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              rd_i,
    input  logic              wr_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              data_valid_o,
    output logic [3:0]        busy_o,
    output logic              stall_o,
    output logic              err_o
);

    localparam int ROW_W = ADDR_W - 3;
    localparam int ROWS  = 1 << ROW_W;

    if (RD_LAT != 2 || BANK_CYCLES < 2 || BANK_CYCLES > 15) begin : g_bad_param
        $error("banked_mem_responder: RD_LAT must be 2 and BANK_CYCLES within 2..15");
    end

    logic [1:0]       bank;
    logic [ROW_W-1:0] row;
    logic             req;
    logic             accept;
    logic             rd_accept;

    logic [3:0] cnt_q [4];
    logic [3:0] cnt_d [4];
    logic [3:0] busy_q;
    logic [3:0] busy_d;

    logic [DATA_W-1:0] mem_q [4][ROWS];

    logic              rd_s1_vld_q;
    logic [DATA_W-1:0] rd_s1_dat_q;
    logic              out_vld_q;
    logic [DATA_W-1:0] out_dat_q;

    assign bank = addr_i[2:1];
    assign row  = addr_i[ADDR_W-1:3];
    assign req  = rd_i | wr_i;

    // Misaligned or simultaneous rd/wr is rejected before the bank check, so err wins over stall.
    assign err_o     = (rd_i & wr_i) | (req & addr_i[0]);
    assign stall_o   = req & ~err_o & busy_q[bank];
    assign accept    = req & ~err_o & ~stall_o;
    assign rd_accept = accept & rd_i;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = cnt_q[b];
            if (accept && bank == 2'(b)) begin
                cnt_d[b] = 4'(BANK_CYCLES);
            end else if (cnt_q[b] != 4'd0) begin
                cnt_d[b] = cnt_q[b] - 4'd1;
            end
            busy_d[b] = (cnt_d[b] != 4'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= 4'd0;
            end
            busy_q <= 4'd0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            busy_q <= busy_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (accept && wr_i) begin
            mem_q[bank][row] <= data_in_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_s1_vld_q <= 1'b0;
            rd_s1_dat_q <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
        end else begin
            rd_s1_vld_q <= rd_accept;
            rd_s1_dat_q <= rd_accept ? mem_q[bank][row] : '0;
            out_vld_q   <= rd_s1_vld_q;
            out_dat_q   <= rd_s1_vld_q ? rd_s1_dat_q : '0;
        end
    end

    assign busy_o       = busy_q;
    assign data_valid_o = out_vld_q;
    assign data_out_o   = out_dat_q;

endmodule
